rom_boot_loader: RTL and testbench
==================================

Name: rom_boot_loader

Overview:
- Boot-time copy engine that sits directly upstream of the ROM as its bus master.
- Reads COPY_WORDS consecutive words from the ROM and writes each one to a destination memory through the same active-low bus handshake.
- Holds the CPU in reset until the copy completes, and reports a 32-bit additive checksum of the copied image.

Parameters:
- ROM_ADDR_W, 11: ROM word-address width.
- MEM_ADDR_W, 30: destination word-address width.
- WORD_W, 32: data word width.
- COPY_WORDS, 2048: number of words to copy; legal range 1 to 2^ROM_ADDR_W.
- DST_BASE, 0: destination word address of the first word.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a copy
- rom_cs_  out  1  ROM chip select, active low
- rom_as_  out  1  ROM address strobe, active low
- rom_addr  out  ROM_ADDR_W  ROM word address
- rom_rd_data  in  WORD_W  ROM read data
- rom_rdy_  in  1  ROM ready, active low
- mem_cs_  out  1  destination chip select, active low
- mem_as_  out  1  destination address strobe, active low
- mem_rw  out  1  1 = read, 0 = write; this block only writes
- mem_addr  out  MEM_ADDR_W  destination word address
- mem_wr_data  out  WORD_W  write data
- mem_rdy_  in  1  destination ready, active low
- busy  out  1  high while a copy is in progress
- done  out  1  sticky completion flag
- cpu_hold  out  1  high holds the CPU in reset
- checksum  out  WORD_W  running sum of copied words

Behaviour:
- Clock and reset: all state is updated on the rising edge of clk. Reset is sampled at that edge and is active-high; there is no asynchronous path.
- Reset values:
  - rom_cs_ = rom_as_ = mem_cs_ = mem_as_ = 1.
  - mem_rw = 1.
  - rom_addr = 0, mem_addr = 0, mem_wr_data = 0.
  - busy = 0, done = 0, cpu_hold = 1, checksum = 0.
  - State = IDLE, word counter = 0.
- ROM slave timing: the ROM asserts rom_rdy_ = 0 in the cycle after it samples cs_ = as_ = 0. rom_rd_data is valid in that same cycle, because the ROM's synchronous block RAM registers the address on the same edge.
- FSM states: IDLE, ROM_REQ, ROM_WAIT, MEM_WR, DONE.
- IDLE:
  - On start = 1: clear checksum and counter, set busy = 1, go to ROM_REQ.
  - Otherwise stay in IDLE.
- ROM_REQ:
  - Drive rom_cs_ = rom_as_ = 0 and rom_addr = counter for exactly one cycle, then go to ROM_WAIT.
- ROM_WAIT:
  - Drive rom_cs_ = rom_as_ = 0 and hold rom_addr.
  - On rom_rdy_ = 0: capture rom_rd_data into mem_wr_data and add it to checksum modulo 2^WORD_W.
  - Then deassert the ROM strobes and go to MEM_WR.
  - With no rom_rdy_, wait indefinitely.
- MEM_WR:
  - Drive mem_cs_ = mem_as_ = 0, mem_rw = 0, mem_addr = DST_BASE + counter (truncated to MEM_ADDR_W), and hold mem_wr_data.
  - On mem_rdy_ = 0 the write completes, the strobes deassert the next cycle, and mem_rw returns to 1.
  - If counter == COPY_WORDS-1, go to DONE. Otherwise increment counter and go to ROM_REQ.
- DONE: busy = 0, done = 1, cpu_hold = 0.
- Word timing: each word costs at least 4 cycles (ROM_REQ, ROM_WAIT with ready, MEM_WR with zero-wait ready, and the transition).
- Strobe exclusivity: ROM and memory strobes are never low in the same cycle.
- start handling:
  - start while busy = 1 is ignored.
  - start in DONE restarts the copy: done clears, cpu_hold returns to 1, and checksum and counter clear.
- Boundaries:
  - COPY_WORDS = 1 does one transfer and then enters DONE.
  - The counter never wraps.
  - rom_addr of the last word = COPY_WORDS-1.
- Reset mid-copy: reset in any state returns all outputs to their reset values on that edge. A partial image is left in memory, done = 0, and cpu_hold = 1.
- Ready edge cases:
  - rom_rdy_ seen low outside ROM_WAIT is ignored.
  - mem_rdy_ seen low outside MEM_WR is ignored.
- Registered outputs: all outputs are registered, with no combinational path from input to output.

Test Plan:
- Reset release check: release reset with no start -> outputs hold reset values; cpu_hold = 1; busy = 0 for 20 cycles.
- Zero-wait copy: COPY_WORDS = 4, ROM contents 0x11111111, 0x22222222, 0x33333333, 0x44444444, DST_BASE = 0x100, zero-wait mem_rdy_, start pulse ->
  - writes land at 0x100-0x103 with matching data;
  - checksum = 0xAAAAAAAA;
  - done = 1 and cpu_hold = 0 within 20 cycles of start;
  - ROM and memory strobes never overlap.
- Memory wait states: mem_rdy_ delayed 3 cycles per write -> strobes, mem_addr and mem_wr_data held stable until ready; same final checksum; completion 12 cycles later than the zero-wait case.
- Checksum wrap: ROM words 0xFFFFFFFF, 0x00000002, COPY_WORDS = 2 -> checksum = 0x00000001.
- Reset mid-copy: reset pulsed during MEM_WR of word 2 -> next edge shows all outputs at reset values; a new start copies from word 0 with checksum restarted at 0.
- Restart behaviour: start while busy is ignored, so the transfer sequence is unchanged; start in DONE -> done drops to 0 and cpu_hold rises to 1 the next cycle, then the full copy repeats.

Source files
------------

// File: rtl/rom_boot_loader.sv
// Boot-time copy engine: masters the ROM bus, copies COPY_WORDS words into a
// destination memory, accumulates an additive checksum and releases the CPU when done.
module rom_boot_loader #(
    parameter int          ROM_ADDR_W = 11,
    parameter int          MEM_ADDR_W = 30,
    parameter int          WORD_W     = 32,
    parameter int          COPY_WORDS = 2048,
    parameter int unsigned DST_BASE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  rom_cs_,
    output logic                  rom_as_,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0]     rom_rd_data,
    input  logic                  rom_rdy_,
    output logic                  mem_cs_,
    output logic                  mem_as_,
    output logic                  mem_rw,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_wr_data,
    input  logic                  mem_rdy_,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_hold,
    output logic [WORD_W-1:0]     checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM_REQ,
        S_ROM_WAIT,
        S_MEM_WR,
        S_DONE
    } state_t;

    localparam logic [ROM_ADDR_W-1:0] LAST_IDX  = ROM_ADDR_W'(COPY_WORDS - 1);
    localparam logic [MEM_ADDR_W-1:0] BASE_ADDR = MEM_ADDR_W'(DST_BASE);

    state_t                r_state;
    logic [ROM_ADDR_W-1:0] r_count;
    logic                  r_rom_stb_;
    logic [ROM_ADDR_W-1:0] r_rom_addr;
    logic                  r_mem_stb_;
    logic                  r_mem_rw;
    logic [MEM_ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0]     r_mem_wr_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cpu_hold;
    logic [WORD_W-1:0]     r_checksum;

    state_t                w_state_nxt;
    logic [ROM_ADDR_W-1:0] w_count_nxt;
    logic                  w_rom_stb_nxt;
    logic [ROM_ADDR_W-1:0] w_rom_addr_nxt;
    logic                  w_mem_stb_nxt;
    logic                  w_mem_rw_nxt;
    logic [MEM_ADDR_W-1:0] w_mem_addr_nxt;
    logic [WORD_W-1:0]     w_mem_wr_data_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_cpu_hold_nxt;
    logic [WORD_W-1:0]     w_checksum_nxt;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_rom_addr_nxt    = r_rom_addr;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wr_data_nxt = r_mem_wr_data;
        w_busy_nxt        = r_busy;
        w_done_nxt        = r_done;
        w_cpu_hold_nxt    = r_cpu_hold;
        w_checksum_nxt    = r_checksum;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt    = S_ROM_REQ;
                    w_count_nxt    = '0;
                    w_rom_addr_nxt = '0;
                    w_checksum_nxt = '0;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_cpu_hold_nxt = 1'b1;
                end
            end
            S_ROM_REQ: begin
                w_state_nxt = S_ROM_WAIT;
            end
            S_ROM_WAIT: begin
                if (!rom_rdy_) begin
                    w_state_nxt       = S_MEM_WR;
                    w_mem_wr_data_nxt = rom_rd_data;
                    w_checksum_nxt    = r_checksum + rom_rd_data;
                    w_mem_addr_nxt    = BASE_ADDR + MEM_ADDR_W'(r_count);
                end
            end
            S_MEM_WR: begin
                if (!mem_rdy_) begin
                    if (r_count == LAST_IDX) begin
                        w_state_nxt    = S_DONE;
                        w_busy_nxt     = 1'b0;
                        w_done_nxt     = 1'b1;
                        w_cpu_hold_nxt = 1'b0;
                    end else begin
                        w_state_nxt    = S_ROM_REQ;
                        w_count_nxt    = r_count + 1'b1;
                        w_rom_addr_nxt = r_count + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Strobes follow the state being entered, so they are registered with it.
        w_rom_stb_nxt = !((w_state_nxt == S_ROM_REQ) || (w_state_nxt == S_ROM_WAIT));
        w_mem_stb_nxt = (w_state_nxt != S_MEM_WR);
        w_mem_rw_nxt  = (w_state_nxt != S_MEM_WR);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_rom_stb_    <= 1'b1;
            r_rom_addr    <= '0;
            r_mem_stb_    <= 1'b1;
            r_mem_rw      <= 1'b1;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cpu_hold    <= 1'b1;
            r_checksum    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_rom_stb_    <= w_rom_stb_nxt;
            r_rom_addr    <= w_rom_addr_nxt;
            r_mem_stb_    <= w_mem_stb_nxt;
            r_mem_rw      <= w_mem_rw_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wr_data <= w_mem_wr_data_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_cpu_hold    <= w_cpu_hold_nxt;
            r_checksum    <= w_checksum_nxt;
        end
    end

    assign rom_cs_     = r_rom_stb_;
    assign rom_as_     = r_rom_stb_;
    assign rom_addr    = r_rom_addr;
    assign mem_cs_     = r_mem_stb_;
    assign mem_as_     = r_mem_stb_;
    assign mem_rw      = r_mem_rw;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cpu_hold    = r_cpu_hold;
    assign checksum    = r_checksum;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Bench for rom_boot_loader: two instances (4-word copy at 0x100, 2-word copy wrapping
// the destination address) with synchronous ROM/memory models and a write scoreboard.
module tb_rom_boot_loader;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic start  = 1'b0;
    logic start2 = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Main instance: 4 words to 0x100
    logic        rom_cs_, rom_as_, mem_cs_, mem_as_, mem_rw, busy, done, cpu_hold;
    logic [10:0] rom_addr;
    logic [29:0] mem_addr;
    logic [31:0] mem_wr_data, checksum;
    logic [31:0] rom_rd_data = '0;
    logic        rom_rdy_    = 1'b1;
    logic        mem_rdy_    = 1'b1;

    // Second instance: 2 words starting at the top of the destination space
    logic        rom_cs2_, rom_as2_, mem_cs2_, mem_as2_, mem_rw2, busy2, done2, cpu_hold2;
    logic [10:0] rom_addr2;
    logic [29:0] mem_addr2;
    logic [31:0] mem_wr_data2, checksum2;
    logic [31:0] rom_rd_data2 = '0;
    logic        rom_rdy2_    = 1'b1;
    logic        mem_rdy2_    = 1'b1;

    rom_boot_loader #(
        .ROM_ADDR_W(11), .MEM_ADDR_W(30), .WORD_W(32), .COPY_WORDS(4), .DST_BASE(32'h100)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_cs_(rom_cs_), .rom_as_(rom_as_), .rom_addr(rom_addr),
        .rom_rd_data(rom_rd_data), .rom_rdy_(rom_rdy_),
        .mem_cs_(mem_cs_), .mem_as_(mem_as_), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rdy_(mem_rdy_),
        .busy(busy), .done(done), .cpu_hold(cpu_hold), .checksum(checksum)
    );

    rom_boot_loader #(
        .ROM_ADDR_W(11), .MEM_ADDR_W(30), .WORD_W(32), .COPY_WORDS(2), .DST_BASE(32'h3FFF_FFFF)
    ) u_dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .rom_cs_(rom_cs2_), .rom_as_(rom_as2_), .rom_addr(rom_addr2),
        .rom_rd_data(rom_rd_data2), .rom_rdy_(rom_rdy2_),
        .mem_cs_(mem_cs2_), .mem_as_(mem_as2_), .mem_rw(mem_rw2), .mem_addr(mem_addr2),
        .mem_wr_data(mem_wr_data2), .mem_rdy_(mem_rdy2_),
        .busy(busy2), .done(done2), .cpu_hold(cpu_hold2), .checksum(checksum2)
    );

    logic [31:0] rom_img  [0:3];
    logic [31:0] rom_img2 [0:1];
    int          mem_wait = 0;
    int          wcnt     = 0;

    // Synchronous slaves: ready (and ROM data) appear the cycle after strobes are sampled low.
    always @(posedge clk) begin
        if (!rom_cs_ && !rom_as_ && rom_rdy_) begin
            rom_rdy_    <= 1'b0;
            rom_rd_data <= rom_img[rom_addr[1:0]];
        end else begin
            rom_rdy_    <= 1'b1;
            rom_rd_data <= 32'hDEAD_BEEF;
        end
        if (!mem_cs_ && !mem_as_ && mem_rdy_) begin
            if (wcnt >= mem_wait) begin
                mem_rdy_ <= 1'b0;
                wcnt     <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            mem_rdy_ <= 1'b1;
            wcnt     <= 0;
        end
    end

    always @(posedge clk) begin
        if (!rom_cs2_ && !rom_as2_ && rom_rdy2_) begin
            rom_rdy2_    <= 1'b0;
            rom_rd_data2 <= rom_img2[rom_addr2[0]];
        end else begin
            rom_rdy2_    <= 1'b1;
            rom_rd_data2 <= 32'hDEAD_BEEF;
        end
        mem_rdy2_ <= !(!mem_cs2_ && !mem_as2_ && mem_rdy2_);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards of expected {addr, data} writes
    logic [61:0] sb  [$];
    logic [61:0] sb2 [$];
    int          writes      = 0;
    int          overlap_cnt = 0;
    int          hold_err    = 0;
    bit          in_wr       = 1'b0;
    logic [29:0] hold_addr;
    logic [31:0] hold_data;

    always @(negedge clk) begin
        logic [63:0] exp;
        if ((!rom_cs_ || !rom_as_) && (!mem_cs_ || !mem_as_)) overlap_cnt++;
        if ((!rom_cs2_ || !rom_as2_) && (!mem_cs2_ || !mem_as2_)) overlap_cnt++;
        if (!mem_cs_ && !mem_as_) begin
            if (in_wr && (mem_addr !== hold_addr || mem_wr_data !== hold_data || mem_rw !== 1'b0))
                hold_err++;
            in_wr     = 1'b1;
            hold_addr = mem_addr;
            hold_data = mem_wr_data;
            if (!mem_rdy_) begin
                writes++;
                exp = (sb.size() > 0) ? 64'(sb.pop_front()) : 64'hFFFF_FFFF_FFFF_FFFF;
                check("mem_write", 64'({mem_addr, mem_wr_data}), exp);
                check("mem_rw_low", 64'(mem_rw), 64'd0);
            end
        end else begin
            in_wr = 1'b0;
        end
        if (!mem_cs2_ && !mem_as2_ && !mem_rdy2_) begin
            exp = (sb2.size() > 0) ? 64'(sb2.pop_front()) : 64'hFFFF_FFFF_FFFF_FFFF;
            check("mem_write2", 64'({mem_addr2, mem_wr_data2}), exp);
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_rom_cs_"},   64'(rom_cs_), 64'd1);
        check({tag, "_rom_as_"},   64'(rom_as_), 64'd1);
        check({tag, "_mem_cs_"},   64'(mem_cs_), 64'd1);
        check({tag, "_mem_as_"},   64'(mem_as_), 64'd1);
        check({tag, "_mem_rw"},    64'(mem_rw), 64'd1);
        check({tag, "_rom_addr"},  64'(rom_addr), 64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr), 64'd0);
        check({tag, "_wr_data"},   64'(mem_wr_data), 64'd0);
        check({tag, "_busy"},      64'(busy), 64'd0);
        check({tag, "_done"},      64'(done), 64'd0);
        check({tag, "_cpu_hold"},  64'(cpu_hold), 64'd1);
        check({tag, "_checksum"},  64'(checksum), 64'd0);
    endtask

    task automatic push_image();
        for (int i = 0; i < 4; i++) sb.push_back({30'h100 + 30'(i), rom_img[i]});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit second, input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget && ((second ? done2 : done) !== 1'b1)) begin
            @(negedge clk);
            cycles++;
        end
        check(second ? "done2_in_budget" : "done_in_budget", 64'(second ? done2 : done), 64'd1);
    endtask

    initial begin
        int c0, c1, idle_bad, found;
        rom_img[0] = 32'h1111_1111; rom_img[1] = 32'h2222_2222;
        rom_img[2] = 32'h3333_3333; rom_img[3] = 32'h4444_4444;
        rom_img2[0] = 32'hFFFF_FFFF; rom_img2[1] = 32'h0000_0002;

        // Reset and 20 idle cycles with no start
        repeat (3) @(negedge clk);
        check_reset("in_reset");
        reset    = 1'b0;
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || rom_cs_ !== 1'b1 || mem_cs_ !== 1'b1)
                idle_bad++;
        end
        check("idle_20_cycles", 64'(idle_bad), 64'd0);
        check_reset("after_idle");

        // Zero-wait copy
        push_image();
        pulse_start();
        check("start_busy", 64'(busy), 64'd1);
        check("start_rom_req", 64'({rom_cs_, rom_as_, rom_addr}), 64'd0);
        wait_done(1'b0, 60, c0);
        check("zero_wait_within_20", 64'(c0 <= 20), 64'd1);
        check("zw_checksum", 64'(checksum), 64'hAAAA_AAAA);
        check("zw_cpu_hold", 64'(cpu_hold), 64'd0);
        check("zw_busy", 64'(busy), 64'd0);
        check("zw_last_rom_addr", 64'(rom_addr), 64'd3);
        check("zw_writes", 64'(writes), 64'd4);
        check("zw_sb_empty", 64'(sb.size()), 64'd0);

        // Restart from DONE with 3 memory wait states; extra starts while busy
        mem_wait = 3;
        push_image();
        pulse_start();
        check("restart_done_clr", 64'(done), 64'd0);
        check("restart_cpu_hold", 64'(cpu_hold), 64'd1);
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_checksum", 64'(checksum), 64'd0);
        repeat (5) @(negedge clk);
        pulse_start();
        wait_done(1'b0, 120, c1);
        check("wait_state_latency", 64'(c1 + 6), 64'(c0 + 12));
        check("ws_checksum", 64'(checksum), 64'hAAAA_AAAA);
        check("ws_hold_stable", 64'(hold_err), 64'd0);
        check("ws_sb_empty", 64'(sb.size()), 64'd0);

        // Reset during MEM_WR of word 2
        mem_wait = 0;
        writes   = 0;
        push_image();
        pulse_start();
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (!mem_cs_ && mem_addr == 30'h102) found = 1;
            else @(negedge clk);
        end
        check("reach_word2_mem_wr", 64'(found), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset("mid_reset");
        check("writes_before_reset", 64'(writes), 64'd2);
        sb.delete();
        reset = 1'b0;
        @(negedge clk);
        push_image();
        pulse_start();
        check("recopy_rom_addr0", 64'(rom_addr), 64'd0);
        check("recopy_checksum0", 64'(checksum), 64'd0);
        wait_done(1'b0, 60, c1);
        check("recopy_checksum", 64'(checksum), 64'hAAAA_AAAA);
        check("recopy_sb_empty", 64'(sb.size()), 64'd0);

        // Checksum wrap and destination address wrap on the 2-word instance
        sb2.push_back({30'h3FFF_FFFF, 32'hFFFF_FFFF});
        sb2.push_back({30'h0000_0000, 32'h0000_0002});
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_done(1'b1, 60, c1);
        check("wrap_checksum", 64'(checksum2), 64'h0000_0001);
        check("wrap_cpu_hold", 64'(cpu_hold2), 64'd0);
        check("wrap_last_rom_addr", 64'(rom_addr2), 64'd1);
        check("wrap_sb_empty", 64'(sb2.size()), 64'd0);

        check("strobe_overlap", 64'(overlap_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
